pos_cell_scheduler: RTL
=======================

POS_CELL_SCHEDULER -- requirements
Module: pos_cell_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, cell RAM word width {posz, posy, posx}.
REQ-002 SHALL have parameter PARTICLE_NUM, default 220, cell RAM depth in words (address 0 is the count word).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, cell RAM address width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, one-cycle pulse requesting a full cell readout.
REQ-007 SHALL have port stall, input, 1 bit, consumer back-pressure; while high, no new read address is issued.
REQ-008 SHALL have port wr_req, input, 1 bit, motion-update writeback request.
REQ-009 SHALL have ports wr_addr (input, ADDR_WIDTH) and wr_data (input, DATA_WIDTH), the writeback address and data.
REQ-010 SHALL have port wr_grant, output, 1 bit, high in the cycle the write is committed to RAM.
REQ-011 SHALL have ports mem_address (output, ADDR_WIDTH), mem_data (output, DATA_WIDTH), mem_rden (output, 1) and mem_wren (output, 1), driving the single-port cell RAM.
REQ-012 SHALL have port mem_q, input, DATA_WIDTH, the RAM read data, valid 2 cycles after the address and rden are presented.
REQ-013 SHALL have ports pos_out (output, DATA_WIDTH), pos_index (output, ADDR_WIDTH) and pos_valid (output, 1), the streamed particle data, its RAM address and its qualifier.
REQ-014 SHALL have ports particle_count (output, ADDR_WIDTH), busy (output, 1), done (output, 1, single-cycle pulse) and count_err (output, 1, sticky).

Function
REQ-015 SHALL implement the states IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN and DONE.
REQ-016 In IDLE, wr_req SHALL take priority: mem_wren=wr_grant=1, mem_address=wr_addr and mem_data=wr_data in the same cycle, combinationally; mem_rden=0.
REQ-017 wr_req outside IDLE SHALL NOT be granted (wr_grant=0); the requester holds it until granted.
REQ-018 A start pulse SHALL set a pending flag; the FSM leaves IDLE for CNT_RD in the first cycle with pending=1 and wr_req=0.
REQ-019 start arriving while busy=1 SHALL be ignored.
REQ-020 CNT_RD SHALL issue address 0 with rden=1 for one cycle and then go to CNT_WAIT.
REQ-021 CNT_WAIT SHALL last 2 cycles.
REQ-022 On the second CNT_WAIT cycle, mem_q[ADDR_WIDTH-1:0] SHALL be captured into particle_count.
REQ-023 If the captured count exceeds PARTICLE_NUM-1, it SHALL be clamped to PARTICLE_NUM-1 and count_err set.
REQ-024 If the count is 0, the FSM SHALL go directly to DONE; otherwise it SHALL go to STREAM with the issue pointer at 1.
REQ-025 In STREAM with stall=0, the block SHALL issue pointer on mem_address with rden=1 and increment the pointer, one address per cycle.
REQ-026 In STREAM with stall=1, rden SHALL be 0 and the pointer SHALL hold.
REQ-027 After issuing address == count, the FSM SHALL enter DRAIN.
REQ-028 Each issued read SHALL produce pos_valid=1 exactly 2 cycles later, with pos_out=mem_q and pos_index equal to the issued address, via a 2-deep valid/index shift pipeline.
REQ-029 In-flight reads SHALL be delivered regardless of stall; the consumer absorbs up to 2 beats after asserting stall.
REQ-030 DRAIN SHALL exit to DONE when the pipeline is empty.
REQ-031 DONE SHALL assert done for one cycle, coincident with the cycle after the last pos_valid, then return to IDLE.
REQ-032 busy SHALL equal (state != IDLE).
REQ-033 mem_rden and mem_wren SHALL never both be 1.
REQ-034 mem_address SHALL be 0 whenever neither rden nor wren is asserted.

Reset
REQ-035 rst SHALL force state=IDLE and clear the pending flag, pointer, pipeline valids and particle_count.
REQ-036 During and after rst, all outputs SHALL be 0: pos_valid, done, busy, wr_grant, mem_rden, mem_wren, count_err, pos_out, pos_index and mem_address.
REQ-037 rst asserted mid-STREAM SHALL abort the readout: no further pos_valid and no done.
REQ-038 count_err SHALL be cleared only by rst.

Verification
REQ-039 count word 3, start, stall=0 -> addresses 0,1,2,3 issued; pos_valid on 3 consecutive cycles with pos_index 1,2,3; done 1 cycle after the last pos_valid.
REQ-040 count word 0, start -> no pos_valid; done asserted 4 cycles after start (CNT_RD, 2x CNT_WAIT, DONE).
REQ-041 count word 250 with PARTICLE_NUM=220 -> particle_count=219, count_err=1, 219 beats delivered.
REQ-042 count 5, stall high for 3 cycles after the 2nd issue -> no issue during stall, 5 total beats in order 1..5, no duplicates or drops.
REQ-043 start and wr_req in the same cycle in IDLE -> write granted first, CNT_RD next cycle; wr_req during STREAM -> wr_grant=0 until return to IDLE.
REQ-044 rst mid-STREAM -> outputs 0 the next cycle; a subsequent start performs a clean full readout.

Source files
------------

// File: rtl/pos_cell_scheduler.sv
// -----------------------------------------------------------------------------
// pos_cell_scheduler
//
// Streams every particle position of one cell out of a single-port cell RAM.
// Word 0 of the RAM holds the particle count. Words 1..count hold the
// positions {posz, posy, posx}. A start pulse reads the count and then issues
// one read per cycle, throttled by stall. Each read returns 2 cycles later as
// a pos_valid beat. The RAM port is shared with a motion-update writeback
// path that is only granted while the scheduler is idle.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : one-cycle pulse requesting a full cell readout
//   stall           : consumer back-pressure (blocks new read issue only)
//   wr_req/wr_addr/wr_data : writeback request, granted combinationally in IDLE
//   wr_grant        : write committed to RAM this cycle
//   mem_address/mem_data/mem_rden/mem_wren : cell RAM command port
//   mem_q           : RAM read data, 2 cycles after address/rden
//   pos_out/pos_index/pos_valid : streamed particle data, address, qualifier
//   particle_count  : captured (clamped) count word
//   busy            : scheduler not idle
//   done            : one-cycle pulse, the cycle after the last beat
//   count_err       : sticky, count word exceeded the RAM depth
// -----------------------------------------------------------------------------
module pos_cell_scheduler #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] pos_out,
  output logic [ADDR_WIDTH-1:0] pos_index,
  output logic                  pos_valid,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err
);

  typedef enum logic [2:0] {
    IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state;
  logic                  pending;
  logic                  wait_cnt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  count_err_q;
  // Two-stage shadow of the RAM read latency: valid and address per stage.
  logic                  v1, v2;
  logic [ADDR_WIDTH-1:0] i1, i2;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] captured;
  logic                  over;

  assign issue    = (state == STREAM) && !stall;
  assign captured = mem_q[ADDR_WIDTH-1:0];
  assign over     = captured > MAX_COUNT;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      wait_cnt    <= 1'b0;
      ptr         <= '0;
      count_q     <= '0;
      count_err_q <= 1'b0;
      // NOTE: the index stages are reset along with the valids so pos_index
      // never shows a stale address from an aborted readout.
      v1          <= 1'b0;
      v2          <= 1'b0;
      i1          <= '0;
      i2          <= '0;
    end else begin
      v1 <= issue;
      i1 <= ptr;
      v2 <= v1;
      i2 <= i1;

      case (state)
        IDLE: begin
          // A write granted this cycle still completes; the count read
          // follows in the next cycle.
          if (start || pending) begin
            state   <= CNT_RD;
            pending <= 1'b0;
          end
        end
        CNT_RD: begin
          state    <= CNT_WAIT;
          wait_cnt <= 1'b0;
        end
        CNT_WAIT: begin
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else begin
            count_q <= over ? MAX_COUNT : captured;
            if (over) count_err_q <= 1'b1;
            ptr     <= ADDR_WIDTH'(1);
            state   <= (captured == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (!stall) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            if (ptr == count_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Stage 2 delivers its beat this cycle; once stage 1 is empty the
          // next cycle is the one right after the last beat.
          if (!v1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Command port: writes only in IDLE, reads only in CNT_RD/STREAM, so
  // rden and wren are mutually exclusive by construction.
  assign wr_grant    = !rst && (state == IDLE) && wr_req;
  assign mem_wren    = wr_grant;
  assign mem_rden    = !rst && ((state == CNT_RD) || issue);
  assign mem_data    = wr_grant ? wr_data : '0;
  assign mem_address = wr_grant              ? wr_addr :
                       (!rst && issue)       ? ptr     : '0;

  assign pos_valid      = !rst && v2;
  assign pos_out        = pos_valid ? mem_q : '0;
  assign pos_index      = pos_valid ? i2    : '0;
  assign particle_count = count_q;
  assign busy           = !rst && (state != IDLE);
  assign done           = !rst && (state == DONE);
  assign count_err      = !rst && count_err_q;

endmodule
